// File: rtl/regfile_mp.sv
// Multi-port integer register file with two write lanes, same-cycle
// write-to-read bypass and a per-register busy scoreboard for issue.
// Register 0 is a constant zero and is never marked busy.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   readAddr,
  output logic [NRD*XLEN-1:0] rdData,
  output logic [NRD-1:0]      rdBusy,
  input  logic                writeEnable0,
  input  logic [AW-1:0]       writeAddr0,
  input  logic [XLEN-1:0]     writeData0,
  input  logic                writeEnable1,
  input  logic [AW-1:0]       writeAddr1,
  input  logic [XLEN-1:0]     writeData1,
  input  logic                issueEn,
  input  logic [AW-1:0]       issueAddr,
  input  logic                flush
);

  // Flattened views of all register contents and busy bits.
  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0]           busy_q;

  genvar gi;

  // One storage element plus one busy bit per architectural register.
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_q[gi] = '0;
        assign busy_q[gi] = 1'b0;
      end else begin : g_live
        logic [XLEN-1:0] value_reg;
        logic            busy_reg;
        logic            hit0;
        logic            hit1;
        logic            issue_hit;

        assign hit0      = writeEnable0 && (writeAddr0 == AW'(gi));
        assign hit1      = writeEnable1 && (writeAddr1 == AW'(gi));
        assign issue_hit = issueEn && (issueAddr == AW'(gi));

        // Data update: lane 1 overrides lane 0 when both target this register.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            value_reg <= '0;
          end else if (hit1) begin
            value_reg <= writeData1;
          end else if (hit0) begin
            value_reg <= writeData0;
          end
        end

        // Busy update: flush beats issue, issue beats a retiring write.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            busy_reg <= 1'b0;
          end else if (flush) begin
            busy_reg <= 1'b0;
          end else if (issue_hit) begin
            busy_reg <= 1'b1;
          end else if (hit0 || hit1) begin
            busy_reg <= 1'b0;
          end
        end

        assign regs_q[gi] = value_reg;
        assign busy_q[gi] = busy_reg;
      end
    end
  endgenerate

  // Combinational read ports with write bypass; outputs forced to zero in reset.
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] word;
      logic            bsy;
      logic            byp0;
      logic            byp1;

      assign addr = readAddr[gi*AW +: AW];
      assign byp0 = writeEnable0 && (writeAddr0 == addr);
      assign byp1 = writeEnable1 && (writeAddr1 == addr);

      // Priority: zero register, lane 1, lane 0, stored value.
      always_comb begin
        word = '0;
        bsy  = 1'b0;
        if (!reset && (addr != '0)) begin
          if (byp1) begin
            word = writeData1;
          end else if (byp0) begin
            word = writeData0;
          end else begin
            word = regs_q[addr];
          end
          bsy = busy_q[addr] && !(byp0 || byp1);
        end
      end

      assign rdData[gi*XLEN +: XLEN] = word;
      assign rdBusy[gi]              = bsy;
    end
  endgenerate

endmodule
